// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter and its picker.
// The default widths below match the default arbiter parameters.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Returns the bit count needed to index 'value' items; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int DEF_NREQ     = 4;
    localparam int DEF_MAXBURST = 16;
    localparam int IDW          = clog2(DEF_NREQ);
    localparam int CNTW         = clog2(DEF_MAXBURST) + 1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after the pointer, cyclically.
// Shared between the write-side arbiter and the read-side scheduler.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_rr_ptr,
    output logic [PW-1:0]   o_winner,
    output logic            o_any_req
);

    logic [PW:0] w_idx;

    // The extra index bit plus an explicit compare keeps the wrap correct when NREQ is not a power of two.
    always_comb begin
        o_winner  = '0;
        o_any_req = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, i_rr_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(NREQ)) begin
                w_idx = w_idx - (PW+1)'(NREQ);
            end
            if (!o_any_req && i_req[w_idx[PW-1:0]]) begin
                o_any_req = 1'b1;
                o_winner  = w_idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-based round-robin arbiter sharing the async FIFO write port among NREQ clients.
// A grant lasts until the last beat or MAXBURST beats; every release costs one IDLE cycle.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 16
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [clog2(NREQ)-1:0]   grant_id,
    output logic                     busy
);

    localparam int GRANT_W = clog2(NREQ);
    localparam int BEAT_W  = clog2(MAXBURST) + 1;

    state_e               r_state;
    logic [GRANT_W-1:0]   r_rr_ptr;
    logic [GRANT_W-1:0]   r_grant_id;
    logic [BEAT_W-1:0]    r_beat_cnt;

    logic [GRANT_W-1:0]   w_winner;
    logic                 w_any_req;
    logic                 w_locked;
    logic                 w_last;
    logic                 w_burst_end;
    logic [GRANT_W-1:0]   w_next_ptr;

    rr_picker #(
        .NREQ (NREQ),
        .PW   (GRANT_W)
    ) u_picker (
        .i_req     (req_valid),
        .i_rr_ptr  (r_rr_ptr),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    assign w_locked    = (r_state == LOCKED);
    assign winc        = w_locked & req_valid[r_grant_id] & ~wfull;
    assign w_last      = req_last[r_grant_id];
    assign w_burst_end = (r_beat_cnt == BEAT_W'(MAXBURST - 1));
    assign w_next_ptr  = (r_grant_id == GRANT_W'(NREQ - 1)) ? '0 : r_grant_id + GRANT_W'(1);
    assign grant_id    = r_grant_id;
    assign busy        = w_locked;

    always_comb begin
        req_ready = '0;
        if (w_locked && !wfull) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    // Full one-hot mux so wdata is always a defined slice, even when no beat is written.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant_id == GRANT_W'(i)) begin
                wdata = req_data[i*DATASIZE +: DATASIZE];
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant_id <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Stalls (wfull or a silent owner) simply hold the grant and the count.
                    if (winc) begin
                        if (w_last || w_burst_end) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios followed by a long random run.
// A transaction-level model predicts each cycle's response; a negedge monitor compares it.
module tb_fifo_wr_arbiter;

    localparam int DATASIZE = 8;
    localparam int NREQ     = 4;
    localparam int MAXBURST = 16;
    localparam int IDW      = 2;
    localparam int WAIT_BOUND = (NREQ - 1) * (MAXBURST + 1);

    typedef struct packed {
        logic                winc;
        logic                busy;
        logic [IDW-1:0]      grant;
        logic [NREQ-1:0]     ready;
        logic [DATASIZE-1:0] data;
    } exp_t;

    logic                     wclk;
    logic                     wrst;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*DATASIZE-1:0] req_data;
    logic [NREQ-1:0]          req_last;
    logic [NREQ-1:0]          req_ready;
    logic                     wfull;
    logic                     winc;
    logic [DATASIZE-1:0]      wdata;
    logic [IDW-1:0]           grant_id;
    logic                     busy;

    fifo_wr_arbiter #(
        .DATASIZE (DATASIZE),
        .NREQ     (NREQ),
        .MAXBURST (MAXBURST)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    logic [DATASIZE-1:0] srcData [NREQ][$];
    bit                  srcLast [NREQ][$];
    exp_t                expQ[$];
    int                  grantLog[$];
    int                  expLog[$];

    int  checks = 0;
    int  errors = 0;
    int  modelAccepted = 0;
    int  dutWinc = 0;
    int  validPct = 100;
    int  fullPct = 0;
    bit  forceFull = 0;
    bit  [NREQ-1:0] holdOff = '0;

    // Model state: owner -1 means no grant is held.
    int  mOwner = -1;
    int  mPtr = 0;
    int  mGrant = 0;
    int  mBeats = 0;

    int  waitCnt [NREQ];
    bit  waitOn  [NREQ];

    task automatic compareVal(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    task automatic pushPacket(input int id, input int len);
        for (int b = 0; b < len; b++) begin
            srcData[id].push_back(DATASIZE'($urandom));
            srcLast[id].push_back(b == len - 1);
        end
    endtask

    task automatic addRun(input int id, input int n);
        for (int k = 0; k < n; k++) expLog.push_back(id);
    endtask

    // Drives one cycle of inputs, predicts the response, then advances the model across the edge.
    task automatic applyStimulus(input bit doReset);
        logic [NREQ*DATASIZE-1:0] dataVec;
        exp_t rec;
        bit   lastFlag;
        wrst = doReset;
        dataVec = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (srcData[i].size() > 0) && !holdOff[i] && ($urandom_range(99) < validPct);
            if (req_valid[i]) begin
                dataVec[i*DATASIZE +: DATASIZE] = srcData[i][0];
                req_last[i] = srcLast[i][0];
            end else begin
                dataVec[i*DATASIZE +: DATASIZE] = DATASIZE'($urandom);
                req_last[i] = 1'($urandom_range(1));
            end
        end
        req_data = dataVec;
        wfull = forceFull || ($urandom_range(99) < fullPct);

        rec = '0;
        rec.busy  = (mOwner >= 0);
        rec.grant = IDW'(mGrant);
        rec.winc  = rec.busy && req_valid[IDW'(mOwner)] && !wfull;
        if (rec.busy && !wfull) rec.ready[IDW'(mOwner)] = 1'b1;
        lastFlag = 0;
        if (rec.winc) begin
            rec.data = srcData[mOwner][0];
            lastFlag = srcLast[mOwner][0];
            void'(srcData[mOwner].pop_front());
            void'(srcLast[mOwner].pop_front());
            modelAccepted++;
        end
        expQ.push_back(rec);

        if (doReset) begin
            mOwner = -1; mPtr = 0; mGrant = 0; mBeats = 0;
        end else if (mOwner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (mOwner < 0 && req_valid[IDW'((mPtr + k) % NREQ)]) begin
                    mOwner = (mPtr + k) % NREQ;
                    mGrant = mOwner;
                    mBeats = 0;
                end
            end
        end else if (rec.winc) begin
            if (lastFlag || mBeats == MAXBURST - 1) begin
                mPtr = (mOwner + 1) % NREQ;
                mOwner = -1;
            end else begin
                mBeats++;
            end
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) applyStimulus(1'b0);
    endtask

    task automatic checkOutput(input string name);
        bit same;
        same = (grantLog.size() == expLog.size());
        for (int k = 0; k < expLog.size() && same; k++) begin
            if (grantLog[k] != expLog[k]) same = 0;
        end
        checks++;
        if (!same) begin
            errors++;
            $display("[TB] FAIL %s: got %0d beats %p expected %0d beats %p", name,
                     grantLog.size(), grantLog, expLog.size(), expLog);
        end
        grantLog.delete();
        expLog.delete();
    endtask

    // Monitor: pops one prediction per cycle and also tracks per-requester waiting time.
    always @(negedge wclk) begin
        exp_t rec;
        if (expQ.size() > 0) begin
            rec = expQ.pop_front();
            compareVal("winc", int'(winc), int'(rec.winc));
            compareVal("busy", int'(busy), int'(rec.busy));
            compareVal("grant_id", int'(grant_id), int'(rec.grant));
            compareVal("req_ready", int'(req_ready), int'(rec.ready));
            compareVal("winc_while_full", int'(winc & wfull), 0);
            if (rec.winc) compareVal("wdata", int'(wdata), int'(rec.data));
            if (winc) begin
                grantLog.push_back(int'(grant_id));
                dutWinc++;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || wrst) begin
                    waitOn[i] = 0;
                end else if (busy && grant_id == IDW'(i)) begin
                    if (waitOn[i]) begin
                        checks++;
                        if (waitCnt[i] > WAIT_BOUND) begin
                            errors++;
                            $display("[TB] FAIL wait_bound req%0d: got %0d cycles limit %0d", i, waitCnt[i], WAIT_BOUND);
                        end
                    end
                    waitOn[i] = 0;
                end else if (!waitOn[i]) begin
                    waitOn[i] = 1;
                    waitCnt[i] = 0;
                end else if (!busy || (req_valid[grant_id] && !wfull)) begin
                    waitCnt[i]++;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            waitOn[i] = 0;
            waitCnt[i] = 0;
        end
        wrst = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        wfull = 1'b0;
        @(posedge wclk);
        @(posedge wclk);
        #1;

        $display("[TB] reset state");
        validPct = 0;
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        validPct = 100;

        $display("[TB] single-beat round robin");
        pushPacket(0, 1); pushPacket(0, 1);
        pushPacket(1, 1); pushPacket(2, 1); pushPacket(3, 1);
        runCycles(12);
        addRun(0, 1); addRun(1, 1); addRun(2, 1); addRun(3, 1); addRun(0, 1);
        checkOutput("rr_order");

        $display("[TB] forced release at MAXBURST");
        pushPacket(2, 20);
        pushPacket(3, 2);
        holdOff[3] = 1'b1;
        runCycles(4);
        holdOff[3] = 1'b0;
        runCycles(26);
        addRun(2, 16); addRun(3, 2); addRun(2, 4);
        checkOutput("maxburst_release");

        $display("[TB] wfull stall mid-packet");
        pushPacket(1, 8);
        runCycles(3);
        forceFull = 1'b1;
        runCycles(5);
        forceFull = 1'b0;
        runCycles(10);
        addRun(1, 8);
        checkOutput("wfull_stall");

        $display("[TB] owner drops valid mid-packet");
        pushPacket(0, 6);
        pushPacket(1, 2);
        runCycles(3);
        holdOff[0] = 1'b1;
        runCycles(3);
        holdOff[0] = 1'b0;
        runCycles(12);
        addRun(0, 6); addRun(1, 2);
        checkOutput("valid_gap");

        $display("[TB] reset during beat 5");
        pushPacket(3, 10);
        pushPacket(1, 2);
        runCycles(5);
        applyStimulus(1'b1);
        runCycles(20);
        addRun(3, 5); addRun(1, 2); addRun(3, 5);
        checkOutput("reset_mid_packet");

        $display("[TB] random traffic");
        validPct = 70;
        fullPct = 20;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (srcData[i].size() < 4) pushPacket(i, int'($urandom_range(20, 1)));
            end
            applyStimulus($urandom_range(999) == 0);
        end
        grantLog.delete();
        compareVal("total_words", dutWinc, modelAccepted);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
